// File: rtl/multdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_pkg
// Description : Shared types and constants for the multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package multdiv_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/multdiv_if.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_if
// Description : Core-side start/operand/result bundle of the multiply/divide
//               unit. The core is the master, the unit is the slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface multdiv_if #(
    parameter int DATA_WIDTH = 32
) ();

    logic                  ctrl_MULT;
    logic                  ctrl_DIV;
    logic [DATA_WIDTH-1:0] data_operandA;
    logic [DATA_WIDTH-1:0] data_operandB;
    logic [DATA_WIDTH-1:0] data_result;
    logic                  data_exception;
    logic                  data_resultRDY;

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY
    );

endinterface
`default_nettype wire

// File: rtl/multdiv_counter.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_counter
// Description : 6-bit iteration counter with clear and enable; flags the
//               final iteration.
// Revision    : 1.0 - initial release
// ============================================================================
module multdiv_counter #(
    parameter int LAST = 31
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic clr,
    input  wire logic en,
    output logic      last
);

    logic [5:0] count_q;
    logic [5:0] count_d;

    // Clear has priority over counting so a restart always begins at zero
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 6'd0;
        end else if (en) begin
            count_d = count_q + 6'd1;
        end
    end

    // Count register
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= 6'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last = (count_q == 6'(LAST));

endmodule
`default_nettype wire

// File: rtl/multdiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_unit
// Description : Multicycle signed multiply (radix-2 Booth) and divide
//               (restoring, on magnitudes) with fixed DATA_WIDTH+1 latency.
// Revision    : 1.0 - initial release
// ============================================================================
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  wire logic clock,
    input  wire logic reset,
    multdiv_if.slave  bus
);

    localparam int W = DATA_WIDTH;
    localparam logic [W-1:0] C_INT_MIN = {1'b1, {(W-1){1'b0}}};

    state_t            state_q, state_d;
    // Booth register: {acc (W+1 bits, guards the most-negative multiplicand), multiplier, q-1}
    logic [2*W+1:0]    booth_q, booth_d;
    logic [W-1:0]      mcand_q, mcand_d;
    logic [W-1:0]      rem_q, rem_d;
    logic [W-1:0]      quo_q, quo_d;
    logic [W-1:0]      dvsr_q, dvsr_d;
    logic              div_neg_q, div_neg_d;
    logic              div_exc_q, div_exc_d;
    logic [W-1:0]      result_q, result_d;
    logic              exception_q, exception_d;

    logic              w_start_mul, w_start_div, w_start;
    logic              w_busy, w_rdy, w_last;
    logic [W:0]        w_acc, w_mcand_ext, w_sum;
    logic [2*W+1:0]    w_booth_step;
    logic [W:0]        w_rem_sh, w_diff;
    logic [W-1:0]      w_rem_step, w_quo_step;
    logic [W:0]        w_prod_hi;
    logic [W-1:0]      w_abs_a, w_abs_b;

    // Multiply wins when both starts arrive together
    assign w_start_mul = bus.ctrl_MULT;
    assign w_start_div = bus.ctrl_DIV & ~bus.ctrl_MULT;
    assign w_start     = bus.ctrl_MULT | bus.ctrl_DIV;

    multdiv_counter #(.LAST(W - 1)) u_counter (
        .clock (clock),
        .reset (reset),
        .clr   (w_start),
        .en    (w_busy),
        .last  (w_last)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a start restarts from any state
    always_comb begin
        state_d = state_q;
        if (w_start_mul) begin
            state_d = MUL;
        end else if (w_start_div) begin
            state_d = DIV;
        end else begin
            case (state_q)
                MUL, DIV: if (w_last) state_d = DONE;
                DONE:     state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        w_busy = (state_q == MUL) || (state_q == DIV);
        w_rdy  = (state_q == DONE);
    end

    // One Booth step and one restoring-division step, evaluated every cycle
    always_comb begin
        w_acc       = booth_q[2*W+1:W+1];
        w_mcand_ext = {mcand_q[W-1], mcand_q};
        case (booth_q[1:0])
            2'b01:   w_sum = w_acc + w_mcand_ext;
            2'b10:   w_sum = w_acc - w_mcand_ext;
            default: w_sum = w_acc;
        endcase
        w_booth_step = {w_sum[W], w_sum, booth_q[W:1]};
        w_prod_hi    = w_booth_step[2*W:W];

        w_rem_sh = {rem_q, quo_q[W-1]};
        w_diff   = w_rem_sh - {1'b0, dvsr_q};
        if (!w_diff[W]) begin
            w_rem_step = w_diff[W-1:0];
            w_quo_step = {quo_q[W-2:0], 1'b1};
        end else begin
            w_rem_step = w_rem_sh[W-1:0];
            w_quo_step = {quo_q[W-2:0], 1'b0};
        end

        w_abs_a = bus.data_operandA[W-1] ? -bus.data_operandA : bus.data_operandA;
        w_abs_b = bus.data_operandB[W-1] ? -bus.data_operandB : bus.data_operandB;
    end

    // Datapath next values: load on start, iterate while busy, capture on the last step
    always_comb begin
        booth_d     = booth_q;
        mcand_d     = mcand_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        div_neg_d   = div_neg_q;
        div_exc_d   = div_exc_q;
        result_d    = result_q;
        exception_d = exception_q;
        if (w_start_mul) begin
            booth_d = {{(W+1){1'b0}}, bus.data_operandB, 1'b0};
            mcand_d = bus.data_operandA;
        end else if (w_start_div) begin
            rem_d     = '0;
            quo_d     = w_abs_a;
            dvsr_d    = w_abs_b;
            div_neg_d = bus.data_operandA[W-1] ^ bus.data_operandB[W-1];
            div_exc_d = (bus.data_operandB == '0) ||
                        ((bus.data_operandA == C_INT_MIN) && (bus.data_operandB == '1));
        end else if (state_q == MUL) begin
            booth_d = w_booth_step;
            if (w_last) begin
                result_d    = w_booth_step[W:1];
                exception_d = !((w_prod_hi == '0) || (w_prod_hi == '1));
            end
        end else if (state_q == DIV) begin
            rem_d = w_rem_step;
            quo_d = w_quo_step;
            if (w_last) begin
                if (div_exc_q) begin
                    result_d = '0;
                end else begin
                    result_d = div_neg_q ? -w_quo_step : w_quo_step;
                end
                exception_d = div_exc_q;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            booth_q     <= '0;
            mcand_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            div_neg_q   <= 1'b0;
            div_exc_q   <= 1'b0;
            result_q    <= '0;
            exception_q <= 1'b0;
        end else begin
            booth_q     <= booth_d;
            mcand_q     <= mcand_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            div_neg_q   <= div_neg_d;
            div_exc_q   <= div_exc_d;
            result_q    <= result_d;
            exception_q <= exception_d;
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exception_q;
    assign bus.data_resultRDY = w_rdy;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_multdiv_unit
// Description : Self-checking bench for multdiv_unit: directed cases plus
//               randomized operations against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multdiv_unit;
    import multdiv_pkg::*;

    logic clock;
    logic reset;
    int   n_tests;
    int   n_fail;

    multdiv_if #(.DATA_WIDTH(32)) bus ();

    multdiv_unit #(.DATA_WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: exact signed arithmetic on 64-bit integers
    task automatic model(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic exc);
        longint p;
        int     sa;
        int     sb;
        if (is_mul) begin
            p   = longint'($signed(a)) * longint'($signed(b));
            res = p[31:0];
            exc = (p != longint'($signed(p[31:0])));
        end else begin
            sa = a;
            sb = b;
            if (sb == 0 || (a == INT_MIN && sb == -1)) begin
                res = 32'd0;
                exc = 1'b1;
            end else begin
                res = 32'(sa / sb);
                exc = 1'b0;
            end
        end
    endtask

    // Issue one start pulse, then measure latency, result and pulse width
    task automatic run_op(input bit is_mul, input bit both, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic exp_exc, input string tag);
        int n;
        @(posedge clock); #1;
        bus.ctrl_MULT     = is_mul | both;
        bus.ctrl_DIV      = !is_mul | both;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(posedge clock); #1;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
        n = 0;
        while (n < 40 && !bus.data_resultRDY) begin
            @(posedge clock); #1;
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'd32);
        check({tag, " result"}, bus.data_result, exp_res);
        check({tag, " exception"}, 32'(bus.data_exception), 32'(exp_exc));
        @(posedge clock); #1;
        check({tag, " rdy width"}, 32'(bus.data_resultRDY), 32'd0);
    endtask

    initial begin
        logic [31:0] a, b, er;
        logic        ee;
        bit          m;
        int          rdy_seen;

        n_tests = 0;
        n_fail  = 0;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset result", bus.data_result, 32'd0);
        check("reset exception", 32'(bus.data_exception), 32'd0);
        check("reset rdy", 32'(bus.data_resultRDY), 32'd0);

        // Directed cases with hand-derived expectations
        run_op(1, 0, 32'd7, -32'sd3, 32'hFFFF_FFEB, 1'b0, "mul 7*-3");
        run_op(1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, "mul ovf");
        run_op(0, 0, 32'd100, -32'sd7, 32'hFFFF_FFF2, 1'b0, "div 100/-7");
        run_op(0, 0, -32'sd7, 32'd2, 32'hFFFF_FFFD, 1'b0, "div -7/2");
        run_op(0, 0, 32'd5, 32'd0, 32'd0, 1'b1, "div by zero");
        run_op(0, 0, INT_MIN, 32'hFFFF_FFFF, 32'd0, 1'b1, "div intmin/-1");
        run_op(1, 0, INT_MIN, 32'hFFFF_FFFF, INT_MIN, 1'b1, "mul intmin*-1");
        run_op(1, 1, 32'd6, 32'd7, 32'd42, 1'b0, "both starts");

        // Restart: multiply aborted by a divide sampled 10 edges later
        @(posedge clock); #1;
        bus.ctrl_MULT = 1'b1;
        bus.data_operandA = 32'd6;
        bus.data_operandB = 32'd7;
        @(posedge clock); #1;
        bus.ctrl_MULT = 1'b0;
        repeat (8) @(posedge clock);
        run_op(0, 0, 32'd9, 32'd3, 32'd3, 1'b0, "abort restart");

        // Reset during a multiply: outputs clear, no ready follows
        @(posedge clock); #1;
        bus.ctrl_MULT = 1'b1;
        bus.data_operandA = 32'd6;
        bus.data_operandB = 32'd7;
        @(posedge clock); #1;
        bus.ctrl_MULT = 1'b0;
        repeat (14) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("midreset result", bus.data_result, 32'd0);
        check("midreset exception", 32'(bus.data_exception), 32'd0);
        check("midreset rdy", 32'(bus.data_resultRDY), 32'd0);
        rdy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (bus.data_resultRDY) rdy_seen++;
        end
        check("midreset no rdy", 32'(rdy_seen), 32'd0);
        run_op(1, 0, 32'd6, 32'd7, 32'd42, 1'b0, "after reset");

        // Randomized operations with corner operands mixed in
        for (int t = 0; t < 40; t++) begin
            m = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       a = INT_MIN;
                1, 2:    a = 32'($signed(16'($urandom)));
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2, 3:    b = 32'($signed(12'($urandom)));
                default: b = $urandom;
            endcase
            model(m, a, b, er, ee);
            run_op(m, 0, a, b, er, ee, m ? "rand mul" : "rand div");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
